// File: rtl/fp_dot_accumulator_if.sv
// Handshake bundle between the FP32 multiplier, the dot-product accumulator and its consumer.
// The out_count wire exists only when FP_ACC_COUNT_EN is defined.
interface fp_dot_accumulator_if #(
   parameter int CNT_W = 8
);
   logic              in_valid;
   logic              in_ready;
   logic [31:0]       in_data;
   logic              in_ovf;
   logic              in_last;
   logic              out_valid;
   logic              out_ready;
   logic [31:0]       out_data;
   logic              out_overflow;
`ifdef FP_ACC_COUNT_EN
   logic [CNT_W-1:0]  out_count;

   modport master (
      output in_valid, in_data, in_ovf, in_last, out_ready,
      input  in_ready, out_valid, out_data, out_overflow, out_count
   );
   modport slave (
      input  in_valid, in_data, in_ovf, in_last, out_ready,
      output in_ready, out_valid, out_data, out_overflow, out_count
   );
`else
   modport master (
      output in_valid, in_data, in_ovf, in_last, out_ready,
      input  in_ready, out_valid, out_data, out_overflow
   );
   modport slave (
      input  in_valid, in_data, in_ovf, in_last, out_ready,
      output in_ready, out_valid, out_data, out_overflow
   );
`endif
endinterface

// File: rtl/fp_dot_accumulator.sv
// Multi-cycle FP32 dot-product accumulator: one shared align/add/normalize datapath, one term per 4 cycles.
// Optional term counter on out_count is enabled by defining FP_ACC_COUNT_EN.
module fp_dot_accumulator #(
   parameter int CNT_W = 8
) (
   input logic                  clk,
   input logic                  rst_n,
   fp_dot_accumulator_if.slave  bus
);
   localparam logic [31:0] QNAN = 32'h7FC0_0000;

   typedef enum logic [2:0] {
      ACCEPT = 3'd0,
      ALIGN  = 3'd1,
      ADD    = 3'd2,
      NORM   = 3'd3,
      DONE   = 3'd4
   } state_t;

   state_t        state_q, state_d;
   logic          in_ready_q, in_ready_d, out_valid_q, out_valid_d;
   logic [31:0]   out_data_q, out_data_d, op_q, op_d, acc_q, acc_d, spec_val_q, spec_val_d;
   logic          out_ovf_q, out_ovf_d, last_q, last_d, sticky_q, sticky_d;
   logic [23:0]   ma_q, ma_d, mb_q, mb_d;
   logic [7:0]    exp_q, exp_d;
   logic          sa_q, sa_d, sb_q, sb_d, spec_q, spec_d, sign_q, sign_d;
   logic [24:0]   sum_q, sum_d;
`ifdef FP_ACC_COUNT_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

   function automatic logic [4:0] lzc24(input logic [23:0] v);
      lzc24 = 5'd24;
      for (int i = 0; i < 24; i++) begin
         if (v[i]) lzc24 = 5'(23 - i);
      end
   endfunction

   function automatic logic [23:0] shr_man(input logic [23:0] m, input logic [7:0] sh);
      shr_man = (sh >= 8'd25) ? 24'd0 : (m >> sh);
   endfunction

   assign bus.in_ready     = in_ready_q;
   assign bus.out_valid    = out_valid_q;
   assign bus.out_data     = out_data_q;
   assign bus.out_overflow = out_ovf_q;
`ifdef FP_ACC_COUNT_EN
   assign bus.out_count    = cnt_q;
`endif

   // Next-state and datapath computation for all FSM stages.
   always_comb begin
      logic        a_nan, b_nan, a_inf, b_inf;
      logic [7:0]  a_e, b_e;
      logic [23:0] a_m, b_m, man_n;
      logic [4:0]  lz;
      logic signed [9:0] exp_n;

      state_d     = state_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_ovf_d   = out_ovf_q;
      op_d        = op_q;
      acc_d       = acc_q;
      last_d      = last_q;
      sticky_d    = sticky_q;
      ma_d        = ma_q;
      mb_d        = mb_q;
      exp_d       = exp_q;
      sa_d        = sa_q;
      sb_d        = sb_q;
      spec_d      = spec_q;
      spec_val_d  = spec_val_q;
      sum_d       = sum_q;
      sign_d      = sign_q;
`ifdef FP_ACC_COUNT_EN
      cnt_d       = cnt_q;
`endif

      // Zero and denormal encodings collapse to exponent 0, mantissa 0.
      a_nan = (op_q[30:23] == 8'hFF) && (op_q[22:0] != 23'd0);
      b_nan = (acc_q[30:23] == 8'hFF) && (acc_q[22:0] != 23'd0);
      a_inf = (op_q[30:23] == 8'hFF) && (op_q[22:0] == 23'd0);
      b_inf = (acc_q[30:23] == 8'hFF) && (acc_q[22:0] == 23'd0);
      a_e   = op_q[30:23];
      b_e   = acc_q[30:23];
      a_m   = (a_e == 8'd0) ? 24'd0 : {1'b1, op_q[22:0]};
      b_m   = (b_e == 8'd0) ? 24'd0 : {1'b1, acc_q[22:0]};

      lz    = lzc24(sum_q[23:0]);
      if (sum_q[24]) begin
         man_n = {1'b0, sum_q[23:1]};
         exp_n = $signed({2'b00, exp_q}) + 10'sd1;
      end else begin
         man_n = {1'b0, 23'(sum_q[22:0] << lz)};
         exp_n = $signed({2'b00, exp_q}) - $signed({5'd0, lz});
      end

      case (state_q)
         ACCEPT: begin
            in_ready_d = 1'b1;
            if (in_ready_q && bus.in_valid) begin
               op_d       = bus.in_data;
               last_d     = bus.in_last;
               sticky_d   = sticky_q | bus.in_ovf;
               in_ready_d = 1'b0;
               state_d    = ALIGN;
`ifdef FP_ACC_COUNT_EN
               cnt_d      = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
`endif
            end else begin
               state_d    = ACCEPT;
            end
         end
         ALIGN: begin
            if (a_nan || b_nan || (a_inf && b_inf && (op_q[31] != acc_q[31]))) begin
               spec_d     = 1'b1;
               spec_val_d = QNAN;
            end else if (a_inf) begin
               spec_d     = 1'b1;
               spec_val_d = {op_q[31], 8'hFF, 23'd0};
            end else if (b_inf) begin
               spec_d     = 1'b1;
               spec_val_d = {acc_q[31], 8'hFF, 23'd0};
            end else begin
               spec_d     = 1'b0;
               spec_val_d = QNAN;
            end
            if (a_e >= b_e) begin
               ma_d  = a_m;
               mb_d  = shr_man(b_m, a_e - b_e);
               exp_d = a_e;
               sa_d  = op_q[31];
               sb_d  = acc_q[31];
            end else begin
               ma_d  = b_m;
               mb_d  = shr_man(a_m, b_e - a_e);
               exp_d = b_e;
               sa_d  = acc_q[31];
               sb_d  = op_q[31];
            end
            state_d = ADD;
         end
         ADD: begin
            if (sa_q == sb_q) begin
               sum_d  = {1'b0, ma_q} + {1'b0, mb_q};
               sign_d = sa_q;
            end else if (ma_q >= mb_q) begin
               sum_d  = {1'b0, ma_q - mb_q};
               sign_d = sa_q;
            end else begin
               sum_d  = {1'b0, mb_q - ma_q};
               sign_d = sb_q;
            end
            state_d = NORM;
         end
         NORM: begin
            if (spec_q) begin
               acc_d = spec_val_q;
            end else if (sum_q == 25'd0) begin
               acc_d = 32'd0;
            end else if (exp_n >= 10'sd255) begin
               acc_d    = {sign_q, 8'hFF, 23'd0};
               sticky_d = 1'b1;
            end else if (exp_n <= 10'sd0) begin
               acc_d = 32'd0;
            end else begin
               acc_d = {sign_q, exp_n[7:0], man_n[22:0]};
            end
            if (last_q) begin
               state_d    = DONE;
               in_ready_d = 1'b0;
            end else begin
               state_d    = ACCEPT;
               in_ready_d = 1'b1;
            end
         end
         DONE: begin
            // First DONE cycle publishes the result; out_valid then holds until accepted.
            if (!out_valid_q) begin
               out_valid_d = 1'b1;
               out_data_d  = acc_q;
               out_ovf_d   = sticky_q;
            end else if (bus.out_ready) begin
               out_valid_d = 1'b0;
               acc_d       = 32'd0;
               sticky_d    = 1'b0;
               in_ready_d  = 1'b1;
               state_d     = ACCEPT;
`ifdef FP_ACC_COUNT_EN
               cnt_d       = {CNT_W{1'b0}};
`endif
            end else begin
               state_d     = DONE;
            end
         end
         default: begin
            state_d    = ACCEPT;
            in_ready_d = 1'b1;
         end
      endcase
   end

   // State, datapath and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ACCEPT;
         in_ready_q <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q <= 32'd0;
         out_ovf_q  <= 1'b0;
         op_q       <= 32'd0;
         acc_q      <= 32'd0;
         last_q     <= 1'b0;
         sticky_q   <= 1'b0;
         ma_q       <= 24'd0;
         mb_q       <= 24'd0;
         exp_q      <= 8'd0;
         sa_q       <= 1'b0;
         sb_q       <= 1'b0;
         spec_q     <= 1'b0;
         spec_val_q <= 32'd0;
         sum_q      <= 25'd0;
         sign_q     <= 1'b0;
`ifdef FP_ACC_COUNT_EN
         cnt_q      <= {CNT_W{1'b0}};
`endif
      end else begin
         state_q    <= state_d;
         in_ready_q <= in_ready_d;
         out_valid_q <= out_valid_d;
         out_data_q <= out_data_d;
         out_ovf_q  <= out_ovf_d;
         op_q       <= op_d;
         acc_q      <= acc_d;
         last_q     <= last_d;
         sticky_q   <= sticky_d;
         ma_q       <= ma_d;
         mb_q       <= mb_d;
         exp_q      <= exp_d;
         sa_q       <= sa_d;
         sb_q       <= sb_d;
         spec_q     <= spec_d;
         spec_val_q <= spec_val_d;
         sum_q      <= sum_d;
         sign_q     <= sign_d;
`ifdef FP_ACC_COUNT_EN
         cnt_q      <= cnt_d;
`endif
      end
   end
endmodule

// File: tb/tb_fp_dot_accumulator.sv
// Directed bench for fp_dot_accumulator: vector table of dot products plus
// backpressure and mid-operation reset sequences.
module tb_fp_dot_accumulator;
   localparam int CNT_W = 8;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   fp_dot_accumulator_if #(.CNT_W(CNT_W)) bus ();
   fp_dot_accumulator #(.CNT_W(CNT_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   typedef struct {
      int          n;
      logic [31:0] d [3];
      logic [2:0]  ovf;
      logic [31:0] exp_data;
      logic        exp_ovf;
      string       name;
   } vec_t;

   vec_t vecs [$];

   task automatic add_vec(input int n, input logic [31:0] d0, input logic [31:0] d1,
                          input logic [31:0] d2, input logic [2:0] ovf,
                          input logic [31:0] exp_data, input logic exp_ovf, input string name);
      vec_t v;
      v.n = n; v.d[0] = d0; v.d[1] = d1; v.d[2] = d2; v.ovf = ovf;
      v.exp_data = exp_data; v.exp_ovf = exp_ovf; v.name = name;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic send_term(input string name, input logic [31:0] d, input logic ovf, input logic last);
      int w;
      bus.in_valid = 1'b1; bus.in_data = d; bus.in_ovf = ovf; bus.in_last = last;
      w = 0;
      @(negedge clk);
      while (!bus.in_ready && w < 20) begin
         @(negedge clk);
         w++;
      end
      chk({name, "_accept"}, {31'd0, bus.in_ready}, 32'd1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0; bus.in_data = 32'd0; bus.in_ovf = 1'b0; bus.in_last = 1'b0;
   endtask

   // Called one step after the last accept edge; counts edges until out_valid.
   task automatic wait_result(input string name);
      int lat;
      lat = 0;
      while (!bus.out_valid && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk({name, "_latency"}, 32'(lat), 32'd4);
   endtask

   task automatic handshake(input string name);
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      chk({name, "_valid_drop"}, {31'd0, bus.out_valid}, 32'd0);
      chk({name, "_ready_back"}, {31'd0, bus.in_ready}, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      bus.in_valid = 1'b0; bus.in_data = 32'd0; bus.in_ovf = 1'b0;
      bus.in_last = 1'b0; bus.out_ready = 1'b0;

      add_vec(3, 32'h3F800000, 32'h40000000, 32'h40400000, 3'b000, 32'h40C00000, 1'b0, "sum123");
      add_vec(2, 32'h40000000, 32'hC0000000, 32'h0,        3'b000, 32'h00000000, 1'b0, "cancel");
      add_vec(2, 32'h3F800000, 32'h33800000, 32'h0,        3'b000, 32'h3F800000, 1'b0, "trunc");
      add_vec(2, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h0,        3'b000, 32'h7F800000, 1'b1, "acc_ovf");
      add_vec(1, 32'h3F800000, 32'h0,        32'h0,        3'b000, 32'h3F800000, 1'b0, "sticky_clr");
      add_vec(2, 32'h7F800000, 32'hFF800000, 32'h0,        3'b000, 32'h7FC00000, 1'b0, "inf_minus_inf");
      add_vec(2, 32'h7FC00000, 32'h3F800000, 32'h0,        3'b000, 32'h7FC00000, 1'b0, "nan_in");
      add_vec(1, 32'h80000000, 32'h0,        32'h0,        3'b000, 32'h00000000, 1'b0, "neg_zero");
      add_vec(1, 32'h00400000, 32'h0,        32'h0,        3'b000, 32'h00000000, 1'b0, "denorm");
      add_vec(2, 32'h3F800000, 32'hBF000000, 32'h0,        3'b000, 32'h3F000000, 1'b0, "sub_norm");
      add_vec(1, 32'hC0400000, 32'h0,        32'h0,        3'b000, 32'hC0400000, 1'b0, "negative");
      add_vec(1, 32'h3F800000, 32'h0,        32'h0,        3'b001, 32'h3F800000, 1'b1, "in_ovf");

      // Reset state while rst_n is held low.
      #12;
      chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
      chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("rst_out_data", bus.out_data, 32'd0);
      chk("rst_out_ovf", {31'd0, bus.out_overflow}, 32'd0);
`ifdef FP_ACC_COUNT_EN
      chk("rst_out_count", 32'(bus.out_count), 32'd0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

      foreach (vecs[k]) begin
         for (int i = 0; i < vecs[k].n; i++)
            send_term(vecs[k].name, vecs[k].d[i], vecs[k].ovf[i], (i == vecs[k].n - 1));
         wait_result(vecs[k].name);
         chk({vecs[k].name, "_data"}, bus.out_data, vecs[k].exp_data);
         chk({vecs[k].name, "_ovf"}, {31'd0, bus.out_overflow}, {31'd0, vecs[k].exp_ovf});
`ifdef FP_ACC_COUNT_EN
         chk({vecs[k].name, "_count"}, 32'(bus.out_count), 32'(vecs[k].n));
`endif
         handshake(vecs[k].name);
      end

      // Backpressure: result held while out_ready stays low; in_valid ignored.
      send_term("bp", 32'h7F800000, 1'b1, 1'b0);
      send_term("bp", 32'h3F800000, 1'b0, 1'b1);
      wait_result("bp");
      bus.in_valid = 1'b1; bus.in_data = 32'h40000000; bus.in_last = 1'b1;
      for (int c = 0; c < 5; c++) begin
         chk("bp_hold_data", bus.out_data, 32'h7F800000);
         chk("bp_hold_ovf", {31'd0, bus.out_overflow}, 32'd1);
         chk("bp_hold_valid", {31'd0, bus.out_valid}, 32'd1);
         chk("bp_hold_in_ready", {31'd0, bus.in_ready}, 32'd0);
`ifdef FP_ACC_COUNT_EN
         chk("bp_hold_count", 32'(bus.out_count), 32'd2);
`endif
         @(posedge clk);
         #1;
      end
      bus.in_valid = 1'b0; bus.in_data = 32'd0; bus.in_last = 1'b0;
      handshake("bp");
      send_term("bp_next", 32'h3F800000, 1'b0, 1'b1);
      wait_result("bp_next");
      chk("bp_next_data", bus.out_data, 32'h3F800000);
      chk("bp_next_ovf", {31'd0, bus.out_overflow}, 32'd0);
      handshake("bp_next");

      // Reset while the second term sits in ADD.
      send_term("mid_rst", 32'h40000000, 1'b0, 1'b0);
      send_term("mid_rst", 32'h40000000, 1'b0, 1'b1);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
      chk("mid_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("mid_rst_out_data", bus.out_data, 32'd0);
      chk("mid_rst_out_ovf", {31'd0, bus.out_overflow}, 32'd0);
      repeat (3) @(posedge clk);
      #1;
      chk("mid_rst_no_result", {31'd0, bus.out_valid}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      send_term("after_rst", 32'h3F800000, 1'b0, 1'b1);
      wait_result("after_rst");
      chk("after_rst_data", bus.out_data, 32'h3F800000);
      chk("after_rst_ovf", {31'd0, bus.out_overflow}, 32'd0);
`ifdef FP_ACC_COUNT_EN
      chk("after_rst_count", 32'(bus.out_count), 32'd1);
`endif
      handshake("after_rst");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
